// File: rtl/dma_datapath_pkg.sv
// Shared defaults and FIFO operation decode for the DMA datapath.
package dma_datapath_pkg;

  localparam int unsigned ADD_LEN_DEF         = 16;
  localparam int unsigned DATA_LEN_DEF        = 16;
  localparam int unsigned FIFO_DEPTH_DEF      = 5;
  localparam int unsigned FIFO_DIV_FACTOR_DEF = 3;

  typedef enum logic [2:0] {
    FIFO_IDLE,
    FIFO_WRITE,
    FIFO_READ,
    FIFO_UNDO_WR,
    FIFO_UNDO_RD,
    FIFO_FLUSH,
    FIFO_HOLD
  } fifo_op_e;

endpackage

// File: rtl/dma_fifo_mem.sv
// First-word fall-through FIFO with flush and single-step rewind of the last operation.
module dma_fifo_mem
  import dma_datapath_pkg::*;
#(
  parameter int unsigned DATA_LEN        = DATA_LEN_DEF,
  parameter int unsigned FIFO_DEPTH      = FIFO_DEPTH_DEF,
  parameter int unsigned FIFO_DIV_FACTOR = FIFO_DIV_FACTOR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fifo_en,
  input  logic                fifo_wr_rd,
  input  logic                fifo_rst,
  input  logic                fifo_old_add_flag,
  input  logic [DATA_LEN-1:0] fifo_in,
  output logic [DATA_LEN-1:0] fifo_out,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                fifo_empty_partial
);

  localparam int unsigned FIFO_WORDS = 2 ** FIFO_DEPTH;
  localparam int unsigned PART_WORDS = 2 ** (FIFO_DEPTH - FIFO_DIV_FACTOR);
  localparam int unsigned OCC_W      = FIFO_DEPTH + 1;

  localparam logic [FIFO_DEPTH-1:0] PTR_ONE  = FIFO_DEPTH'(1);
  localparam logic [OCC_W-1:0]      OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0]      OCC_FULL = OCC_W'(FIFO_WORDS);
  localparam logic [OCC_W-1:0]      OCC_PART = OCC_W'(PART_WORDS);

  logic [DATA_LEN-1:0]   mem [FIFO_WORDS];
  logic [FIFO_DEPTH-1:0] wr_ptr;
  logic [FIFO_DEPTH-1:0] rd_ptr;
  logic [OCC_W-1:0]      occ;
  logic                  old_flag_q;
  fifo_op_e              op;

  assign fifo_out           = mem[rd_ptr];
  assign fifo_full          = (occ == OCC_FULL);
  assign fifo_empty         = (occ == '0);
  assign fifo_empty_partial = (occ <= OCC_PART);

  // Rewind fires only on the rising edge of the flag; while it stays high the FIFO freezes.
  always_comb begin
    op = FIFO_IDLE;
    if (fifo_rst) begin
      op = FIFO_FLUSH;
    end else if (fifo_old_add_flag && !old_flag_q) begin
      if (fifo_wr_rd) begin
        if (!fifo_empty) op = FIFO_UNDO_WR;
      end else begin
        if (!fifo_full) op = FIFO_UNDO_RD;
      end
    end else if (fifo_old_add_flag) begin
      op = FIFO_HOLD;
    end else if (fifo_en) begin
      if (fifo_wr_rd && !fifo_full)       op = FIFO_WRITE;
      else if (!fifo_wr_rd && !fifo_empty) op = FIFO_READ;
    end
  end

  // Storage shares the reset-gated branch so a write cannot land while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      old_flag_q <= 1'b0;
    end else begin
      old_flag_q <= fifo_old_add_flag;
      case (op)
        FIFO_FLUSH: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          occ    <= '0;
        end
        FIFO_WRITE: begin
          mem[wr_ptr] <= fifo_in;
          wr_ptr      <= wr_ptr + PTR_ONE;
          occ         <= occ + OCC_ONE;
        end
        FIFO_READ: begin
          rd_ptr <= rd_ptr + PTR_ONE;
          occ    <= occ - OCC_ONE;
        end
        FIFO_UNDO_WR: begin
          wr_ptr <= wr_ptr - PTR_ONE;
          occ    <= occ - OCC_ONE;
        end
        FIFO_UNDO_RD: begin
          rd_ptr <= rd_ptr - PTR_ONE;
          occ    <= occ + OCC_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dma_datapath.sv
// DMA datapath: word/address registers, transfer counter, address mux and staging FIFO.
module dma_datapath
  import dma_datapath_pkg::*;
#(
  parameter int unsigned ADD_LEN         = ADD_LEN_DEF,
  parameter int unsigned DATA_LEN        = DATA_LEN_DEF,
  parameter int unsigned FIFO_DEPTH      = FIFO_DEPTH_DEF,
  parameter int unsigned FIFO_DIV_FACTOR = FIFO_DIV_FACTOR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADD_LEN-1:0]  num_words,
  input  logic                words_reg_en,
  input  logic                words_rst,
  input  logic [ADD_LEN:0]    start_addr,
  input  logic                addr0_reg_en,
  input  logic                addr0_rst,
  input  logic                old_addr_reg_en,
  input  logic                old_addr_rst,
  input  logic                count_en,
  input  logic                count_load,
  input  logic                count_rst,
  input  logic                fifo_en,
  input  logic                fifo_wr_rd,
  input  logic                fifo_rst,
  input  logic                fifo_old_add_flag,
  input  logic [DATA_LEN-1:0] fifo_in,
  input  logic                addr_sel,
  input  logic                addr_drive,
  output logic [DATA_LEN-1:0] fifo_out,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                fifo_empty_partial,
  output logic [ADD_LEN-1:0]  words,
  output logic [ADD_LEN-1:0]  count,
  output logic                end_count,
  output logic [ADD_LEN-1:0]  dma_addr,
  output logic                flag_cnt_words,
  output logic                flag_cnt_words_read,
  output logic                security_violation
);

  localparam logic [ADD_LEN-1:0] ADDR_ONE = ADD_LEN'(1);

  logic [ADD_LEN-1:0] start_address;
  logic [ADD_LEN-1:0] old_address;
  logic [ADD_LEN-1:0] address;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             words <= '0;
    else if (words_rst)    words <= '0;
    else if (words_reg_en) words <= num_words;
  end

  // Byte address in, word address stored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             start_address <= '0;
    else if (addr0_rst)    start_address <= '0;
    else if (addr0_reg_en) start_address <= ADD_LEN'(start_addr >> 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                old_address <= '0;
    else if (old_addr_rst)    old_address <= '0;
    else if (old_addr_reg_en) old_address <= address;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           count <= '0;
    else if (count_rst)  count <= '0;
    else if (count_load) count <= '0;
    else if (count_en)   count <= count + ADDR_ONE;
  end

  assign address             = start_address + count;
  assign end_count           = &count;
  assign dma_addr            = addr_drive ? (addr_sel ? old_address : address) : '0;
  assign flag_cnt_words      = (count == (words - ADDR_ONE));
  assign flag_cnt_words_read = (count == words);
  assign security_violation  = (num_words == '0);

  dma_fifo_mem #(
    .DATA_LEN        (DATA_LEN),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .FIFO_DIV_FACTOR (FIFO_DIV_FACTOR)
  ) u_fifo (
    .clk                (clk),
    .reset              (reset),
    .fifo_en            (fifo_en),
    .fifo_wr_rd         (fifo_wr_rd),
    .fifo_rst           (fifo_rst),
    .fifo_old_add_flag  (fifo_old_add_flag),
    .fifo_in            (fifo_in),
    .fifo_out           (fifo_out),
    .fifo_full          (fifo_full),
    .fifo_empty         (fifo_empty),
    .fifo_empty_partial (fifo_empty_partial)
  );

endmodule

// File: tb/tb_dma_datapath.sv
// Directed and randomized checks of dma_datapath against a queue/arithmetic reference model.
module tb_dma_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] num_words;
  logic        words_reg_en, words_rst;
  logic [16:0] start_addr;
  logic        addr0_reg_en, addr0_rst;
  logic        old_addr_reg_en, old_addr_rst;
  logic        count_en, count_load, count_rst;
  logic        fifo_en, fifo_wr_rd, fifo_rst, fifo_old_add_flag;
  logic [15:0] fifo_in;
  logic        addr_sel, addr_drive;
  logic [15:0] fifo_out;
  logic        fifo_full, fifo_empty, fifo_empty_partial;
  logic [15:0] words, count, dma_addr;
  logic        end_count, flag_cnt_words, flag_cnt_words_read, security_violation;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic        m_prev_flag   = 1'b0;
  logic [15:0] m_last_rd     = '0;
  logic        m_last_rd_ok  = 1'b0;
  int unsigned m_words = 0, m_start = 0, m_old = 0, m_count = 0;

  dma_datapath #(
    .ADD_LEN         (16),
    .DATA_LEN        (16),
    .FIFO_DEPTH      (5),
    .FIFO_DIV_FACTOR (3)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .num_words           (num_words),
    .words_reg_en        (words_reg_en),
    .words_rst           (words_rst),
    .start_addr          (start_addr),
    .addr0_reg_en        (addr0_reg_en),
    .addr0_rst           (addr0_rst),
    .old_addr_reg_en     (old_addr_reg_en),
    .old_addr_rst        (old_addr_rst),
    .count_en            (count_en),
    .count_load          (count_load),
    .count_rst           (count_rst),
    .fifo_en             (fifo_en),
    .fifo_wr_rd          (fifo_wr_rd),
    .fifo_rst            (fifo_rst),
    .fifo_old_add_flag   (fifo_old_add_flag),
    .fifo_in             (fifo_in),
    .addr_sel            (addr_sel),
    .addr_drive          (addr_drive),
    .fifo_out            (fifo_out),
    .fifo_full           (fifo_full),
    .fifo_empty          (fifo_empty),
    .fifo_empty_partial  (fifo_empty_partial),
    .words               (words),
    .count               (count),
    .end_count           (end_count),
    .dma_addr            (dma_addr),
    .flag_cnt_words      (flag_cnt_words),
    .flag_cnt_words_read (flag_cnt_words_read),
    .security_violation  (security_violation)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_checks();
    check("fifo_full",    32'(fifo_full),          32'(mq.size() == 32));
    check("fifo_empty",   32'(fifo_empty),         32'(mq.size() == 0));
    check("fifo_partial", 32'(fifo_empty_partial), 32'(mq.size() <= 4));
    if (mq.size() > 0) check("fifo_out", 32'(fifo_out), 32'(mq[0]));
  endtask

  task automatic ctl_idle();
    words_reg_en = 0; words_rst = 0; addr0_reg_en = 0; addr0_rst = 0;
    old_addr_reg_en = 0; old_addr_rst = 0; count_en = 0; count_load = 0; count_rst = 0;
  endtask

  // One FIFO clock: drive, clock, advance the queue model, compare.
  task automatic fifo_cycle(input logic en, input logic wr, input logic [15:0] d, input logic flag);
    logic rd_ok;
    rd_ok = 1'b0;
    fifo_en = en; fifo_wr_rd = wr; fifo_in = d; fifo_old_add_flag = flag;
    @(posedge clk); #1;
    if (flag && !m_prev_flag) begin
      if (wr) begin
        if (mq.size() > 0) void'(mq.pop_back());
      end else if (mq.size() < 32 && m_last_rd_ok) begin
        mq.push_front(m_last_rd);
      end
    end else if (!flag && en) begin
      if (wr && mq.size() < 32) mq.push_back(d);
      else if (!wr && mq.size() > 0) begin
        m_last_rd = mq.pop_front();
        rd_ok = 1'b1;
      end
    end
    m_prev_flag  = flag;
    m_last_rd_ok = rd_ok;
    fifo_checks();
  endtask

  task automatic ctl_checks();
    int unsigned exp_addr;
    exp_addr = addr_drive ? (addr_sel ? m_old : (m_start + m_count) % 65536) : 0;
    check("count",          32'(count),               m_count);
    check("words",          32'(words),               m_words);
    check("end_count",      32'(end_count),           32'(m_count == 65535));
    check("dma_addr",       32'(dma_addr),            exp_addr);
    check("flag_cnt_words", 32'(flag_cnt_words),      32'(m_count == (m_words + 65535) % 65536));
    check("flag_words_read",32'(flag_cnt_words_read), 32'(m_count == m_words));
    check("security",       32'(security_violation),  32'(num_words == 0));
  endtask

  task automatic ctl_step();
    int unsigned cur_addr;
    cur_addr = (m_start + m_count) % 65536;
    @(posedge clk); #1;
    if (words_rst) m_words = 0; else if (words_reg_en) m_words = num_words;
    if (addr0_rst) m_start = 0; else if (addr0_reg_en) m_start = int'(start_addr) / 2;
    if (old_addr_rst) m_old = 0; else if (old_addr_reg_en) m_old = cur_addr;
    if (count_rst || count_load) m_count = 0; else if (count_en) m_count = (m_count + 1) % 65536;
    m_prev_flag = fifo_old_add_flag;
    ctl_checks();
  endtask

  initial begin
    logic        wr;
    int unsigned n;
    reset = 1; num_words = 0; start_addr = 0; fifo_en = 0; fifo_wr_rd = 0; fifo_rst = 0;
    fifo_old_add_flag = 0; fifo_in = 0; addr_sel = 0; addr_drive = 1;
    ctl_idle();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_empty",      32'(fifo_empty), 1);
    check("rst_full",       32'(fifo_full), 0);
    check("rst_partial",    32'(fifo_empty_partial), 1);
    check("rst_count",      32'(count), 0);
    check("rst_end_count",  32'(end_count), 0);
    check("rst_dma_addr",   32'(dma_addr), 0);
    check("rst_words_read", 32'(flag_cnt_words_read), 1);
    check("rst_words",      32'(words), 0);
    reset = 0;

    // Fill to full, overflow ignored, drain in order
    for (int i = 1; i <= 32; i++) fifo_cycle(1, 1, 16'(i), 0);
    check("fill_full", 32'(fifo_full), 1);
    fifo_cycle(1, 1, 16'hDEAD, 0);
    check("overflow_full", 32'(fifo_full), 1);
    for (int i = 1; i <= 32; i++) begin
      check("drain_data", 32'(fifo_out), i);
      fifo_cycle(1, 0, 0, 0);
    end
    check("drain_empty", 32'(fifo_empty), 1);
    fifo_cycle(1, 0, 0, 0);
    check("underflow_empty", 32'(fifo_empty), 1);

    // Partial-empty threshold
    for (int i = 0; i < 5; i++) fifo_cycle(1, 1, 16'(16'h0100 + i), 0);
    check("partial_occ5", 32'(fifo_empty_partial), 0);
    fifo_cycle(1, 0, 0, 0);
    check("partial_occ4", 32'(fifo_empty_partial), 1);
    while (mq.size() > 0) fifo_cycle(1, 0, 0, 0);

    // Rewind of last write, flag held three cycles
    fifo_cycle(1, 1, 16'h00AA, 0);
    fifo_cycle(1, 1, 16'h00BB, 0);
    fifo_cycle(1, 1, 16'h00CC, 0);
    for (int i = 0; i < 3; i++) fifo_cycle(1, 1, 16'h0EEE, 1);
    fifo_cycle(1, 1, 16'h00DD, 0);
    check("rewind_a", 32'(fifo_out), 32'h00AA); fifo_cycle(1, 0, 0, 0);
    check("rewind_b", 32'(fifo_out), 32'h00BB); fifo_cycle(1, 0, 0, 0);
    check("rewind_d", 32'(fifo_out), 32'h00DD); fifo_cycle(1, 0, 0, 0);
    check("rewind_empty", 32'(fifo_empty), 1);

    // Rewind of last read
    fifo_cycle(1, 1, 16'h1111, 0);
    fifo_cycle(1, 1, 16'h2222, 0);
    fifo_cycle(1, 0, 0, 0);
    fifo_cycle(0, 0, 0, 1);
    check("unread_data", 32'(fifo_out), 32'h1111);
    fifo_cycle(0, 0, 0, 0);

    // Flush
    fifo_rst = 1;
    @(posedge clk); #1;
    fifo_rst = 0;
    mq.delete(); m_prev_flag = 0; m_last_rd_ok = 0;
    check("flush_empty", 32'(fifo_empty), 1);
    fifo_cycle(1, 1, 16'h3333, 0);

    // Randomized FIFO traffic with occasional rewind pulses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        wr = m_last_rd_ok ? 1'($urandom_range(0, 1)) : 1'b1;
        n = $urandom_range(1, 3);
        for (int k = 0; k < int'(n); k++) fifo_cycle(1'($urandom_range(0, 1)), wr, 16'($urandom), 1);
      end else begin
        if (mq.size() < 8)       wr = ($urandom_range(0, 3) != 0);
        else if (mq.size() > 28) wr = ($urandom_range(0, 3) == 0);
        else                     wr = 1'($urandom_range(0, 1));
        fifo_cycle(($urandom_range(0, 4) != 0), wr, 16'($urandom), 0);
      end
    end
    fifo_cycle(0, 0, 0, 0);
    fifo_en = 0;

    // Address/count walk
    start_addr = 17'h0100; num_words = 16'd3; words_reg_en = 1; addr0_reg_en = 1; count_load = 1;
    addr_drive = 1; addr_sel = 0;
    ctl_step();
    ctl_idle();
    check("walk_addr0", 32'(dma_addr), 32'h0080);
    count_en = 1;
    ctl_step();
    check("walk_addr1", 32'(dma_addr), 32'h0081);
    ctl_step();
    check("walk_addr2", 32'(dma_addr), 32'h0082);
    check("walk_flag_words", 32'(flag_cnt_words), 1);
    old_addr_reg_en = 1;
    ctl_step();
    ctl_idle();
    check("walk_words_read", 32'(flag_cnt_words_read), 1);
    addr_sel = 1; #1;
    check("walk_old_addr", 32'(dma_addr), 32'h0082);
    addr_drive = 0; #1;
    check("walk_undriven", 32'(dma_addr), 0);
    num_words = 0; #1;
    check("security_zero", 32'(security_violation), 1);

    // Counter wrap
    count_load = 1;
    ctl_step();
    ctl_idle();
    count_en = 1;
    repeat (65534) @(posedge clk);
    m_count = 65534;
    ctl_step();
    check("end_count_max", 32'(end_count), 1);
    ctl_step();
    check("wrap_zero", 32'(count), 0);
    ctl_idle();

    // Randomized register/counter control
    for (int i = 0; i < 200; i++) begin
      words_rst       = ($urandom_range(0, 15) == 0);
      words_reg_en    = ($urandom_range(0, 3) == 0);
      num_words       = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      start_addr      = 17'($urandom);
      addr0_reg_en    = ($urandom_range(0, 7) == 0);
      addr0_rst       = ($urandom_range(0, 31) == 0);
      old_addr_reg_en = ($urandom_range(0, 3) == 0);
      old_addr_rst    = ($urandom_range(0, 15) == 0);
      count_en        = ($urandom_range(0, 2) != 0);
      count_load      = ($urandom_range(0, 15) == 0);
      count_rst       = ($urandom_range(0, 31) == 0);
      addr_sel        = 1'($urandom_range(0, 1));
      addr_drive      = ($urandom_range(0, 3) != 0);
      ctl_step();
    end
    ctl_idle();

    // Reset in the middle of a write burst
    num_words = 16'd5; words_reg_en = 1; count_en = 1;
    ctl_step();
    ctl_step();
    ctl_idle();
    for (int i = 0; i < 3; i++) fifo_cycle(1, 1, 16'(16'h0500 + i), 0);
    fifo_en = 1; fifo_wr_rd = 1; fifo_in = 16'hBEEF;
    #2 reset = 1;
    #1;
    check("async_empty", 32'(fifo_empty), 1);
    check("async_count", 32'(count), 0);
    check("async_words", 32'(words), 0);
    @(posedge clk); #1;
    check("async_hold_empty", 32'(fifo_empty), 1);
    fifo_en = 0;
    reset = 0;
    mq.delete(); m_prev_flag = 0; m_last_rd_ok = 0;
    m_words = 0; m_start = 0; m_old = 0; m_count = 0;
    fifo_cycle(1, 1, 16'h1234, 0);
    check("post_reset_data", 32'(fifo_out), 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_datapath.md
DMA_DATAPATH -- requirements
Module: dma_datapath

Interface
REQ-001 Parameters SHALL be: ADD_LEN, default 16, address/count width; DATA_LEN, default 16, data width; FIFO_DEPTH, default 5, FIFO holds 2^FIFO_DEPTH words; FIFO_DIV_FACTOR, default 3, partial-empty divider exponent.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 sole clock; reset in 1 asynchronous active-high reset; num_words in ADD_LEN word-count value; words_reg_en in 1 load words; words_rst in 1 sync clear words; start_addr in ADD_LEN+1 logical byte address; addr0_reg_en in 1 load start address; addr0_rst in 1 sync clear start address; old_addr_reg_en in 1 capture current address; old_addr_rst in 1 sync clear old address; count_en in 1 increment; count_load in 1 load zero; count_rst in 1 sync clear count; fifo_en in 1 FIFO operation enable; fifo_wr_rd in 1 1=write, 0=read; fifo_rst in 1 sync FIFO flush; fifo_old_add_flag in 1 rewind request; fifo_in in DATA_LEN write data; addr_sel in 1 1=old address; addr_drive in 1 enables dma_addr; fifo_out out DATA_LEN read data; fifo_full out 1; fifo_empty out 1; fifo_empty_partial out 1; words out ADD_LEN; count out ADD_LEN; end_count out 1; dma_addr out ADD_LEN; flag_cnt_words out 1; flag_cnt_words_read out 1; security_violation out 1.

Function
REQ-003 Registers (words, start_address, old_address): sync clear has priority over enable; enable loads on rising clk; otherwise hold.
REQ-004 start_address SHALL load start_addr shifted right by one (physical word address, ADD_LEN bits).
REQ-005 old_address SHALL load the current address value (start_address + count) when old_addr_reg_en=1.
REQ-006 Counter: priority count_rst > count_load > count_en; load value 0; increment wraps mod 2^ADD_LEN; end_count=1 combinationally when count is all ones.
REQ-007 address = start_address + count, truncated to ADD_LEN bits.
REQ-008 dma_addr = addr_drive ? (addr_sel ? old_address : address) : 0.
REQ-009 flag_cnt_words = (count == words-1 mod 2^ADD_LEN); flag_cnt_words_read = (count == words); both combinational.
REQ-010 security_violation = 1 combinationally when num_words (raw input) equals 0.
REQ-011 FIFO: single storage array of 2^FIFO_DEPTH x DATA_LEN, write pointer, read pointer, occupancy counter 0..2^FIFO_DEPTH.
REQ-012 Write: fifo_en=1, fifo_wr_rd=1, not full, old-flag inactive -> store fifo_in at wr_ptr, wr_ptr+1 (wraps), occupancy+1.
REQ-013 Read: fifo_en=1, fifo_wr_rd=0, not empty, old-flag inactive -> rd_ptr+1 (wraps), occupancy-1.
REQ-014 fifo_out SHALL combinationally present mem[rd_ptr] (first-word fall-through); undefined content when empty is permitted.
REQ-015 Write when full and read when empty SHALL be ignored (no pointer/occupancy change, no data corruption).
REQ-016 fifo_full = occupancy == 2^FIFO_DEPTH; fifo_empty = occupancy == 0; fifo_empty_partial = occupancy <= 2^(FIFO_DEPTH-FIFO_DIV_FACTOR) (4 with defaults).
REQ-017 Rewind: first cycle of fifo_old_add_flag=1 (previous cycle 0) SHALL undo the last operation once — fifo_wr_rd=1: wr_ptr-1, occupancy-1; fifo_wr_rd=0: rd_ptr-1, occupancy+1; skipped if that would leave occupancy outside 0..2^FIFO_DEPTH.
REQ-018 While fifo_old_add_flag stays 1 after the first cycle, pointers and occupancy SHALL hold regardless of fifo_en.
REQ-019 fifo_rst SHALL synchronously zero both pointers and occupancy; storage contents unchanged.
REQ-020 Pointer wrap from 2^FIFO_DEPTH-1 to 0 SHALL be seamless for both pointers.

Reset
REQ-021 reset=1 SHALL asynchronously clear words, start_address, old_address, count, both FIFO pointers, occupancy, rewind-edge flag; outputs after reset: fifo_empty=1, fifo_full=0, fifo_empty_partial=1, count=0, end_count=0, dma_addr=0, flag_cnt_words_read=1 (words=0).
REQ-022 reset asserted mid-operation SHALL abort any operation; no write completes in that cycle.

Structure
REQ-023 Shared package SHALL hold default widths (ADD_LEN, DATA_LEN, FIFO_DEPTH, FIFO_DIV_FACTOR).
REQ-024 The FIFO SHALL be one sub-module, dma_fifo_mem; registers and counter are inline.

Verification
REQ-025 Reset, then write 32 words 0x0001..0x0020 -> fifo_full=1 after 32nd; 33rd write ignored; 32 reads return 0x0001..0x0020 in order, fifo_empty=1.
REQ-026 Occupancy 5 -> fifo_empty_partial=0; one read -> occupancy 4, fifo_empty_partial=1.
REQ-027 Write A,B,C, hold fifo_old_add_flag=1 3 cycles with wr_rd=1 -> occupancy 2; next write D; reads return A,B,D.
REQ-028 start_addr=0x0100, num_words=3, load; count 0..2 -> address 0x0080..0x0082; flag_cnt_words=1 at count 2, flag_cnt_words_read=1 at count 3; addr_sel=1 returns captured old_address.
REQ-029 num_words=0 -> security_violation=1; count at 0xFFFF -> end_count=1, next increment -> 0.
REQ-030 Assert reset during FIFO write burst -> all state cleared immediately, fifo_empty=1.
